// File: rtl/aq_vlsu_ld_wb_queue.sv
// aq_vlsu_ld_wb_queue: in-order write-back queue from the load align buffer to the VRF.
// Tracks destination vreg/beat per popped 64-bit beat and pulses done after the last entry.
module aq_vlsu_ld_wb_queue #(
    parameter int DEPTH = 4,
    parameter int BEATS = 2,
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic          forever_cpuclk,
    input  logic          vlsu_rst,
    input  logic          rtu_yy_xx_flush,
    input  logic          inst_start,
    input  logic [4:0]    inst_vd,
    input  logic          ab_wb_vld,
    input  logic [63:0]   ab_wb_data,
    input  logic [7:0]    ab_wb_bytes_vld,
    input  logic          ab_wb_last,
    output logic          wbq_full,
    output logic          vrf_wr_vld,
    input  logic          vrf_wr_rdy,
    output logic [63:0]   vrf_wr_data,
    output logic [7:0]    vrf_wr_be,
    output logic [4:0]    vrf_wr_reg,
    output logic [BW-1:0] vrf_wr_beat,
    output logic          wbq_done,
    output logic          wbq_idle
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    state_t state, state_n;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [72:0] mem [DEPTH];
    logic push, pop, head_last, last_beat;
    assign wbq_full = count == CW'(DEPTH);
    assign vrf_wr_vld = count != '0;
    // only ACTIVE accepts beats: IDLE ignores strays, DRAIN blocks the next instruction's beats
    assign push = ab_wb_vld && !wbq_full && state == ACTIVE;
    assign pop = vrf_wr_vld && vrf_wr_rdy;
    assign head_last = mem[rd_ptr][0];
    assign last_beat = vrf_wr_beat == BW'(BEATS - 1);
    // storage is unreset, so gate the visible fields with valid
    assign vrf_wr_data = vrf_wr_vld ? mem[rd_ptr][72:9] : '0;
    assign vrf_wr_be = vrf_wr_vld ? mem[rd_ptr][8:1] : '0;
    assign wbq_idle = state == IDLE && count == '0;
    always_comb begin
        state_n = state;
        state_n = rtu_yy_xx_flush ? IDLE :
                  state == IDLE && inst_start ? ACTIVE :
                  state == ACTIVE && push && ab_wb_last ? DRAIN :
                  state == DRAIN && pop && head_last ? IDLE : state;
    end
    always_ff @(posedge forever_cpuclk) begin
        if (vlsu_rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge forever_cpuclk) begin
        if (push)
            mem[wr_ptr] <= {ab_wb_data, ab_wb_bytes_vld, ab_wb_last};
    end
    always_ff @(posedge forever_cpuclk) begin
        if (vlsu_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            wbq_done <= 1'b0;
            vrf_wr_reg <= '0;
            vrf_wr_beat <= '0;
        end else if (rtu_yy_xx_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            wbq_done <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CW'(push) - CW'(pop);
            wbq_done <= pop && head_last;
            if (state == IDLE && inst_start) begin
                vrf_wr_reg <= inst_vd;
                vrf_wr_beat <= '0;
            end else if (pop) begin
                vrf_wr_beat <= last_beat ? '0 : vrf_wr_beat + BW'(1);
                vrf_wr_reg <= last_beat ? vrf_wr_reg + 5'd1 : vrf_wr_reg;
            end
        end
    end
endmodule
